// File: rtl/hpam_pkg.sv
// -----------------------------------------------------------------------------
// hpam_pkg
// Shared helpers for the HPAM approximate multiplier pipeline.
//   prod_w()  : product width for a given operand width (2*WIDTH)
//   clamp_k() : saturate a requested approximation level to the largest
//               level the instance supports
// No ports (package).
// -----------------------------------------------------------------------------
package hpam_pkg;

    function automatic int unsigned prod_w(input int unsigned width);
        return 2 * width;
    endfunction

    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned max_k);
        return (k > max_k) ? max_k : k;
    endfunction

endpackage

// File: rtl/hpam_col_reduce.sv
// -----------------------------------------------------------------------------
// hpam_col_reduce
// Combinational partial-product compressor with low-column approximation.
// Columns c >= k are summed exactly through a carry-save (full-adder per
// column) chain; columns c < k are replaced by the OR of their partial
// products and never produce a carry.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   k    : approximation level, already clamped by the caller
//   p    : 2*WIDTH-bit result (exact when k == 0)
// -----------------------------------------------------------------------------
module hpam_col_reduce
    import hpam_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned KW    = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [KW-1:0]      k,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned PW = prod_w(WIDTH);

    logic [PW-1:0] exact_mask;
    logic [PW-1:0] row;
    logic [PW-1:0] masked;
    logic [PW-1:0] or_v;
    logic [PW-1:0] sum_v;
    logic [PW-1:0] carry_v;
    logic [PW-1:0] maj;

    // NOTE: blocking assignments are deliberate here: each loop iteration
    // consumes the sum/carry vectors the previous iteration just produced.
    always_comb begin
        exact_mask = '1 << k;      // ones in columns that are summed exactly
        row        = '0;
        masked     = '0;
        maj        = '0;
        or_v       = '0;
        sum_v      = '0;
        carry_v    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            // Row i holds pp[i][j] in column i+j.
            row     = a[i] ? (PW'(b) << i) : '0;
            or_v    = or_v | row;
            masked  = row & exact_mask;
            // 3:2 compression of (sum, carry, new row); the carry out of the
            // top column is dropped because the exact part is below 2^PW.
            maj     = (sum_v & carry_v) | (sum_v & masked) | (carry_v & masked);
            sum_v   = sum_v ^ carry_v ^ masked;
            carry_v = maj << 1;
        end
        // Exact part has zeros below column k, so the OR'd low columns
        // can be merged without an adder.
        p = (sum_v + carry_v) | (or_v & ~exact_mask);
    end

endmodule

// File: rtl/hpam_mul_pipe.sv
// -----------------------------------------------------------------------------
// hpam_mul_pipe
// Pipelined WIDTH x WIDTH unsigned multiplier with per-beat approximation
// level K, valid/ready on both sides and full backpressure.
// Stage layout:
//   STAGES = 1 : reduce on the inputs, register the product
//   STAGES >= 2: operand register -> reduce -> (STAGES-2) product registers
//                -> output register
// All stages advance together when the output is empty or being consumed.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; in_a, in_b operands, in_k level
//   out_valid/out_ready  result handshake; out_p product, out_k level used
//   occupancy            number of valid beats currently held, 0..STAGES
// -----------------------------------------------------------------------------
module hpam_mul_pipe
    import hpam_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 3,
    parameter int unsigned MAX_K  = 8,
    parameter int unsigned KW     = $clog2(MAX_K + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [KW-1:0]      in_k,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [KW-1:0]      out_k,
    output logic [2:0]         occupancy
);

    localparam int unsigned PW = prod_w(WIDTH);

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("hpam_mul_pipe: STAGES must be in 1..4");
    end
    if (MAX_K > 2 * WIDTH - 1) begin : g_bad_max_k
        $error("hpam_mul_pipe: MAX_K must be in 0..2*WIDTH-1");
    end

    typedef struct packed {
        logic [KW-1:0]    k;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_rec_t;

    typedef struct packed {
        logic [KW-1:0] k;
        logic [PW-1:0] p;
    } prod_rec_t;

    logic              adv;
    logic [KW-1:0]     k_in_eff;
    logic [STAGES-1:0] vld_d;
    logic [STAGES-1:0] vld_q;
    opnd_rec_t         red_in;
    logic [PW-1:0]     red_p;
    prod_rec_t         red_rec;
    prod_rec_t         tail_rec;
    logic              tail_vld;
    prod_rec_t         out_d;
    prod_rec_t         out_q;

    // Whole pipe moves as one; in_ready depends on out_ready, never on in_valid.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign k_in_eff = KW'(clamp_k(32'(in_k), MAX_K));

    // ---------------------------------------------------------------- operands
    if (STAGES > 1) begin : g_opnd
        opnd_rec_t opnd_d;
        opnd_rec_t opnd_q;

        always_comb begin
            opnd_d = opnd_q;
            if (adv && in_valid) begin
                opnd_d = '{k: k_in_eff, a: in_a, b: in_b};
            end
        end

        // NOTE: datapath registers carry no reset; the valid bit beside each
        // one decides whether its contents mean anything. Only the output
        // register is reset, because out_p/out_k are visible after reset.
        always_ff @(posedge clk) begin
            opnd_q <= opnd_d;
        end

        assign red_in   = opnd_q;
        assign tail_vld = vld_q[STAGES-2];
    end else begin : g_no_opnd
        assign red_in   = '{k: k_in_eff, a: in_a, b: in_b};
        assign tail_vld = in_valid;
    end

    // ------------------------------------------------------------ compressor
    hpam_col_reduce #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_col_reduce (
        .a (red_in.a),
        .b (red_in.b),
        .k (red_in.k),
        .p (red_p)
    );

    assign red_rec = '{k: red_in.k, p: red_p};

    // --------------------------------------------------- intermediate products
    if (STAGES > 2) begin : g_mid
        localparam int unsigned NM = STAGES - 2;
        prod_rec_t mid_d [NM];
        prod_rec_t mid_q [NM];

        // mid_q[i] is pipeline stage i+1, so its source valid is vld_q[i].
        always_comb begin
            mid_d[0] = mid_q[0];
            if (adv && vld_q[0]) begin
                mid_d[0] = red_rec;
            end
            for (int i = 1; i < int'(NM); i++) begin
                mid_d[i] = mid_q[i];
                if (adv && vld_q[i]) begin
                    mid_d[i] = mid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            mid_q <= mid_d;
        end

        assign tail_rec = mid_q[NM-1];
    end else begin : g_no_mid
        assign tail_rec = red_rec;
    end

    // ------------------------------------------------------- valid chain / out
    // NOTE: every always_comb output gets a default before any condition, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = in_valid;
            for (int i = 1; i < int'(STAGES); i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // Load only real beats so out_p holds its last result across bubbles.
    always_comb begin
        out_d = out_q;
        if (adv && tail_vld) begin
            out_d = tail_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            out_q <= '0;
        end else begin
            vld_q <= vld_d;
            out_q <= out_d;
        end
    end

    // Bubbles are never collapsed, so the beat count is the count of set valids.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            occupancy = occupancy + 3'(vld_q[i]);
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_p     = out_q.p;
    assign out_k     = out_q.k;

endmodule

// File: tb/tb_hpam_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_hpam_mul_pipe
// Self-checking bench for hpam_mul_pipe (WIDTH=8, STAGES=3, MAX_K=8).
// A column-count model predicts every result; a scoreboard queue holds beats
// accepted but not yet consumed and is compared against the DUT each cycle.
// -----------------------------------------------------------------------------
module tb_hpam_mul_pipe;

    localparam int W     = 8;
    localparam int MAXK  = 8;
    localparam int KWID  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_a = '0;
    logic [W-1:0]    in_b = '0;
    logic [KWID-1:0] in_k = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  out_p;
    logic [KWID-1:0] out_k;
    logic [2:0]      occupancy;

    hpam_mul_pipe #(
        .WIDTH  (W),
        .STAGES (3),
        .MAX_K  (MAXK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_k     (out_k),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int n_out  = 0;

    typedef struct {
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [KWID-1:0] ke;
        logic [2*W-1:0]  p;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Column model: count partial products per column, then weight each
    // column by its count (exact) or by "any bit set" (approximate).
    function automatic logic [2*W-1:0] model_p(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        int cnt [2*W];
        longint unsigned acc;
        acc = 0;
        for (int c = 0; c < 2*W; c++) cnt[c] = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (a[i] && b[j]) cnt[i+j]++;
        for (int c = 0; c < 2*W; c++) begin
            if (c < k) begin
                if (cnt[c] != 0) acc += (64'd1 << c);
            end else begin
                acc += longint'(cnt[c]) << c;
            end
        end
        return acc[2*W-1:0];
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [KWID-1:0] k);
        exp_t e;
        int ke;
        ke   = (int'(k) > MAXK) ? MAXK : int'(k);
        e.a  = a;
        e.b  = b;
        e.ke = KWID'(ke);
        e.p  = model_p(a, b, ke);
        return e;
    endfunction

    // Compare process: outputs and handshake inputs are stable at negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            check("occupancy", 32'(occupancy), 32'(sb.size()));
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("out_valid_without_pending_beat", 32'(out_valid), 32'd0);
                end else begin
                    cur = sb[0];
                    check("out_p", 32'(out_p), 32'(cur.p));
                    check("out_k", 32'(out_k), 32'(cur.ke));
                    check("approx_le_exact", 32'(out_p <= 16'(cur.a) * 16'(cur.b)), 32'd1);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(make_exp(in_a, in_b, in_k));
        end
    end

    // Single beat into an empty pipe; returns result and edges to out_valid.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [KWID-1:0] k,
                           output logic [2*W-1:0] p, output logic [KWID-1:0] ko, output int lat);
        in_valid = 1'b1; in_a = a; in_b = b; in_k = k; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        p  = out_p;
        ko = out_k;
        @(posedge clk); #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [KWID-1:0] k);
        int  n;
        logic acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1; in_a = a; in_b = b; in_k = k;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        check("send_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*W-1:0]  p;
        logic [KWID-1:0] ko;
        int              lat;
        int              n0;

        // Model pinned against hand-computed values.
        check("model_255x255_k0", 32'(model_p(8'd255, 8'd255, 0)), 32'd65025);
        check("model_3x3_k4",     32'(model_p(8'd3, 8'd3, 4)),     32'd7);
        check("model_255x255_k8", 32'(model_p(8'd255, 8'd255, 8)), 32'd63487);

        // Reset state.
        #23;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_p",     32'(out_p),     32'd0);
        check("rst_out_k",     32'(out_k),     32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single beats: latency and literal results.
        run_one(8'd255, 8'd255, 4'd0, p, ko, lat);
        check("latency", 32'(lat), 32'd3);
        check("p_255x255_k0", 32'(p), 32'd65025);
        run_one(8'd0, 8'd173, 4'd0, p, ko, lat);
        check("p_0x173", 32'(p), 32'd0);
        run_one(8'd3, 8'd3, 4'd4, p, ko, lat);
        check("p_3x3_k4", 32'(p), 32'd7);
        check("k_3x3_k4", 32'(ko), 32'd4);
        run_one(8'd255, 8'd255, 4'd15, p, ko, lat);
        check("k_clamped", 32'(ko), 32'd8);
        check("p_255x255_k8", 32'(p), 32'd63487);

        // Exhaustive K=0, back-to-back.
        n0 = n_out;
        out_ready = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                in_valid = 1'b1; in_a = a[7:0]; in_b = b[7:0]; in_k = '0;
                @(posedge clk); #1;
                if (a == 4 && b == 0) begin
                    check("stream_occupancy", 32'(occupancy), 32'd3);
                    check("stream_out_valid", 32'(out_valid), 32'd1);
                end
            end
        end
        drain();
        check("stream_count", 32'(n_out - n0), 32'd65536);

        // Backpressure with a full pipe.
        n0 = n_out;
        out_ready = 1'b0;
        send(8'd200, 8'd100, 4'd0);
        send(8'd77,  8'd91,  4'd3);
        send(8'd129, 8'd255, 4'd8);
        in_valid = 1'b1; in_a = 8'd15; in_b = 8'd17; in_k = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready",  32'(in_ready),  32'd0);
            check("bp_occupancy", 32'(occupancy), 32'd3);
            check("bp_out_p",     32'(out_p),     32'd20000);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'd15, 8'd17, 4'd2);
        drain();
        check("bp_count", 32'(n_out - n0), 32'd4);

        // Reset with the pipe full.
        out_ready = 1'b0;
        send(8'd1, 8'd2, 4'd0);
        send(8'd3, 8'd4, 4'd0);
        send(8'd5, 8'd6, 4'd0);
        check("pre_rst_occupancy", 32'(occupancy), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_occupancy", 32'(occupancy), 32'd0);
        check("mid_rst_out_p",     32'(out_p),     32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        run_one(8'd12, 8'd13, 4'd0, p, ko, lat);
        check("post_rst_p", 32'(p), 32'd156);

        // Random valid/ready traffic, K over the full field (clamping included).
        begin
            int   n_acc;
            int   cyc;
            logic acc;
            n_acc = 0;
            cyc   = 0;
            n0    = n_out;
            in_valid = 1'b0;
            while (n_acc < 2000 && cyc < 20000) begin
                if (!in_valid && $urandom_range(0, 9) < 7) begin
                    in_valid = 1'b1;
                    in_a = 8'($urandom);
                    in_b = 8'($urandom);
                    in_k = 4'($urandom_range(0, 15));
                end
                out_ready = ($urandom_range(0, 9) < 7);
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                cyc++;
                if (acc) begin
                    n_acc++;
                    in_valid = 1'b0;
                end
            end
            check("random_all_accepted", 32'(n_acc), 32'd2000);
            drain();
            check("random_count", 32'(n_out - n0), 32'd2000);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
